aibnd_dll_lockctl: RTL
======================

AIBND_DLL_LOCKCTL -- requirements
Module: aibnd_dll_lockctl

Interface
REQ-001 SHALL have parameter SAT_LIMIT, default 8, the number of consecutive saturated updates that raise sat_err.
REQ-002 SHALL have ports:
  clk_pll  in  1  sole clock; the delay-line reference clock.
  reinit  in  1  reset; synchronous, active-high.
  lock_req  in  1  level request to acquire and hold lock.
  entest  in  1  test mode; forces the static code.
  t_up  in  1  phase-detector "delay too short", synchronous to clk_pll.
  t_down  in  1  phase-detector "delay too long", synchronous to clk_pll.
  csr_init_code  in  10  start/static binary delay code.
  csr_settle  in  3  settle period selector.
  csr_lock_thresh  in  4  direction reversals required for lock.
  i_gray  out  3  gray-coded coarse code, code[9:7].
  f_gray  out  7  gray-coded fine code, code[6:0].
  code_valid  out  1  delay-line code enable.
  dll_phdet_reset_n  out  1  phase-detector reset, active-low.
  dll_lock  out  1  lock indication.
  sat_err  out  1  sticky saturation flag.
  code_bin  out  10  current binary code (status).

Function
REQ-003 SHALL implement FSM states IDLE, PDRST, SETTLE, SAMPLE, LOCKED.
REQ-004 IDLE: code=csr_init_code, code_valid=0, dll_phdet_reset_n=0, dll_lock=0; lock_req=1 and entest=0 -> PDRST.
REQ-005 PDRST: code_valid=1, dll_phdet_reset_n=0 for exactly 4 cycles -> SETTLE.
REQ-006 SETTLE: dll_phdet_reset_n=1; wait (csr_settle+1)*4 cycles -> SAMPLE (from LOCKED tracking, same wait).
REQ-007 SAMPLE (1 cycle) SHALL apply the following:
  - t_up=1, t_down=0 -> code+1, saturating at 1023.
  - t_down=1, t_up=0 -> code-1, saturating at 0.
  - both or neither -> hold.
REQ-008 SHALL keep last nonzero direction; a step opposite to it increments an 4-bit reversal counter (saturating at 15); hold steps do not change direction or counter.
REQ-009 In SAMPLE, reversals >= max(csr_lock_thresh,1) after the update -> LOCKED, else -> SETTLE.
REQ-010 LOCKED: dll_lock=1, tracking continues via SETTLE/SAMPLE timing with the REQ-007 rules; dll_lock stays 1 until lock_req=0 or reinit.
REQ-011 lock_req=0 in any non-IDLE state -> IDLE next cycle; counters and direction clear; code reloads csr_init_code.
REQ-012 A step clipped at 0 or 1023 counts as saturated; SAT_LIMIT consecutive saturated steps in the same direction set sat_err; sat_err clears only on reinit.
REQ-013 While sat_err=1, the FSM SHALL NOT enter LOCKED; an already asserted dll_lock drops next cycle.
REQ-014 entest=1 SHALL have the following effect:
  - FSM held/forced to IDLE.
  - code=csr_init_code, code_valid=1, dll_lock=0.
  - dll_phdet_reset_n=0.
REQ-015 i_gray=bin2gray(code[9:7]) and f_gray=bin2gray(code[6:0]), registered one cycle after the code register; code_bin SHALL equal the code register, zero added latency.
REQ-016 Coarse and fine gray SHALL update in the same cycle; fine wrap 127->0 with coarse+1 is a single code step.
REQ-017 A csr_* change SHALL take effect at the next use (next IDLE load, next settle start, next SAMPLE compare).

Reset
REQ-018 reinit=1 at a clk_pll edge SHALL produce the following state:
  - State: IDLE.
  - Code: csr_init_code; i_gray/f_gray follow one cycle later.
  - Outputs: code_valid=0, dll_phdet_reset_n=0, dll_lock=0, sat_err=0.
  - Counters: reversal and saturation counters 0; direction none.
REQ-019 reinit SHALL take priority over lock_req, entest and any state, including mid-settle and LOCKED.

Verification
REQ-020 Acquire: init=512, settle=0, thresh=2, lock_req=1.
  - Stimulus: t_up for 3 samples, then t_down, t_up.
  - Response: code 512->515->514->515; dll_lock=1 at the cycle after the second reversal sample.
REQ-021 Timing: settle=1, lock_req rises at cycle 0.
  - Response: dll_phdet_reset_n rises at cycle 5; first SAMPLE at cycle 13.
REQ-022 Saturation: init=1020, t_up held.
  - Response: code stops at 1023; sat_err=1 after 8 saturated samples; dll_lock never asserts.
REQ-023 Gray boundary: code 127->128.
  - Response: f_gray 1000000->0000000 and i_gray 000->001 in the same cycle, one cycle after code_bin changes.
REQ-024 Abort: lock_req=0 or reinit=1 while LOCKED.
  - Response: next cycle IDLE, dll_lock=0, code_bin=csr_init_code, code_valid=0.
REQ-025 entest: entest=1 mid-SETTLE.
  - Response: IDLE; code_valid=1, dll_phdet_reset_n=0, code_bin=csr_init_code; t_up pulses ignored.

Source files
------------

// File: rtl/aibnd_dll_lockctl.sv
`timescale 1ns/1ps
// DLL lock controller: steps a 10-bit delay code from phase-detector
// up/down votes, declares lock after enough reversals, flags saturation.
module aibnd_dll_lockctl #(
  parameter int SAT_LIMIT = 8
) (
  input  logic       clk_pll,
  input  logic       reinit,
  input  logic       lock_req,
  input  logic       entest,
  input  logic       t_up,
  input  logic       t_down,
  input  logic [9:0] csr_init_code,
  input  logic [2:0] csr_settle,
  input  logic [3:0] csr_lock_thresh,
  output logic [2:0] i_gray,
  output logic [6:0] f_gray,
  output logic       code_valid,
  output logic       dll_phdet_reset_n,
  output logic       dll_lock,
  output logic       sat_err,
  output logic [9:0] code_bin
);

  localparam int SW = $clog2(SAT_LIMIT + 1);
  localparam logic [SW-1:0] SAT_MAX = SW'(SAT_LIMIT);

  typedef enum logic [2:0] {
    IDLE, PDRST, SETTLE, SAMPLE, LOCKED
  } state_t;

  state_t        st_q, st_d;
  logic [4:0]    cnt_q;
  logic [4:0]    last_q;
  logic [9:0]    code_q, code_nx;
  logic          dir_v_q, dir_v_nx;
  logic          dir_up_q, dir_up_nx;
  logic [3:0]    rev_q, rev_nx;
  logic [SW-1:0] sat_q, sat_nx;
  logic          sat_err_q, sat_err_nx;
  logic          lock_q;
  logic          tm_q;
  logic [2:0]    i_gray_q;
  logic [6:0]    f_gray_q;

  logic       up, dn, clip, stepped;
  logic [3:0] thr;
  logic       rev_ok;

  assign up      = t_up & ~t_down;
  assign dn      = t_down & ~t_up;
  assign stepped = up | dn;
  assign clip    = (up & (code_q == 10'h3FF))
                 | (dn & (code_q == 10'h000));
  assign thr     = (csr_lock_thresh == 4'd0) ? 4'd1
                                             : csr_lock_thresh;
  assign rev_ok  = (rev_nx >= thr);

  // Sample-cycle update of code, direction, reversal and saturation tracking
  always_comb begin
    code_nx    = code_q;
    dir_v_nx   = dir_v_q;
    dir_up_nx  = dir_up_q;
    rev_nx     = rev_q;
    sat_nx     = sat_q;
    sat_err_nx = sat_err_q;
    if (st_q == SAMPLE && stepped) begin
      if (up && !clip) code_nx = code_q + 10'd1;
      if (dn && !clip) code_nx = code_q - 10'd1;
      dir_v_nx  = 1'b1;
      dir_up_nx = up;
      if (dir_v_q && (dir_up_q != up) && (rev_q != 4'hF))
        rev_nx = rev_q + 4'd1;
      if (clip) begin
        if (sat_q != SAT_MAX) sat_nx = sat_q + 1'b1;
      end else begin
        sat_nx = '0;
      end
      if (sat_nx == SAT_MAX) sat_err_nx = 1'b1;
    end
  end

  // Next-state logic; dropping lock_req or test mode always returns to IDLE
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:   if (lock_req && !entest) st_d = PDRST;
      PDRST:  if (cnt_q == 5'd3) st_d = SETTLE;
      SETTLE: if (cnt_q == last_q) st_d = SAMPLE;
      LOCKED: if (cnt_q == last_q) st_d = SAMPLE;
      SAMPLE: st_d = ((lock_q || rev_ok) && !sat_err_nx)
                     ? LOCKED : SETTLE;
      default: st_d = IDLE;
    endcase
    if (!lock_req || entest) st_d = IDLE;
  end

  // State, timer and tracking registers
  always_ff @(posedge clk_pll) begin
    if (reinit) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      last_q    <= {csr_settle, 2'b11};
      code_q    <= csr_init_code;
      dir_v_q   <= 1'b0;
      dir_up_q  <= 1'b0;
      rev_q     <= '0;
      sat_q     <= '0;
      sat_err_q <= 1'b0;
      lock_q    <= 1'b0;
      tm_q      <= 1'b0;
    end else begin
      st_q      <= st_d;
      tm_q      <= entest;
      sat_err_q <= sat_err_nx;
      if (st_d != st_q) cnt_q <= '0;
      else              cnt_q <= cnt_q + 5'd1;
      if (st_d != st_q && (st_d == SETTLE || st_d == LOCKED))
        last_q <= {csr_settle, 2'b11};
      if (st_d == IDLE || st_q == IDLE) begin
        code_q   <= csr_init_code;
        dir_v_q  <= 1'b0;
        dir_up_q <= 1'b0;
        rev_q    <= '0;
        sat_q    <= '0;
        lock_q   <= 1'b0;
      end else begin
        code_q   <= code_nx;
        dir_v_q  <= dir_v_nx;
        dir_up_q <= dir_up_nx;
        rev_q    <= rev_nx;
        sat_q    <= sat_nx;
        if (sat_err_nx)
          lock_q <= 1'b0;
        else if (st_q == SAMPLE && st_d == LOCKED)
          lock_q <= 1'b1;
      end
    end
  end

  // Gray encode one cycle behind the binary code; both halves move together
  always_ff @(posedge clk_pll) begin
    i_gray_q <= code_q[9:7] ^ {1'b0, code_q[9:8]};
    f_gray_q <= code_q[6:0] ^ {1'b0, code_q[6:1]};
  end

  assign i_gray            = i_gray_q;
  assign f_gray            = f_gray_q;
  assign code_bin          = code_q;
  assign code_valid        = (st_q != IDLE) | tm_q;
  assign dll_phdet_reset_n = (st_q == SETTLE) | (st_q == SAMPLE)
                           | (st_q == LOCKED);
  assign dll_lock          = lock_q;
  assign sat_err           = sat_err_q;

endmodule
